// File: rtl/dot_accum.sv
// rtl/dot_accum.sv - streaming signed dot-product accumulator with a 2-entry result queue
module dot_accum #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_prod,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_sum,
    output logic [LEN_W-1:0]    out_count,
    output logic                out_ovf
);
    localparam int PW = 2 * DATA_W;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             first_q, first_d;

    logic [ACC_W-1:0] h_sum_q, h_sum_d, t_sum_q, t_sum_d;
    logic [LEN_W-1:0] h_cnt_q, h_cnt_d, t_cnt_q, t_cnt_d;
    logic             h_ovf_q, h_ovf_d, t_ovf_q, t_ovf_d;
    logic [1:0]       occ_q, occ_d;

    logic [ACC_W-1:0] p, base, nsum;
    logic [LEN_W-1:0] cnt_new;
    logic             ovf_new, beat_ovf, accept, push, pop;

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign out_sum   = h_sum_q;
    assign out_count = h_cnt_q;
    assign out_ovf   = h_ovf_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && in_last;
    assign pop    = out_valid && out_ready;

    assign p        = {{(ACC_W-PW){in_prod[PW-1]}}, in_prod};
    assign base     = first_q ? '0 : acc_q;
    assign nsum     = base + p;
    assign beat_ovf = (base[ACC_W-1] == p[ACC_W-1]) && (nsum[ACC_W-1] != p[ACC_W-1]);
    assign ovf_new  = (first_q ? 1'b0 : ovf_q) | beat_ovf;
    assign cnt_new  = first_q ? LEN_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1));

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        h_sum_d = h_sum_q;
        h_cnt_d = h_cnt_q;
        h_ovf_d = h_ovf_q;
        t_sum_d = t_sum_q;
        t_cnt_d = t_cnt_q;
        t_ovf_d = t_ovf_q;
        occ_d   = occ_q + {1'b0, push} - {1'b0, pop};

        if (accept) begin
            if (in_last) begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                first_d = 1'b1;
            end else begin
                acc_d   = nsum;
                cnt_d   = cnt_new;
                ovf_d   = ovf_new;
                first_d = 1'b0;
            end
        end

        if (pop && occ_q == 2'd2) begin
            h_sum_d = t_sum_q;
            h_cnt_d = t_cnt_q;
            h_ovf_d = t_ovf_q;
        end

        // A push lands in the head slot whenever the head is empty or being vacated this cycle.
        if (push) begin
            if (occ_q == 2'd0 || pop) begin
                h_sum_d = nsum;
                h_cnt_d = cnt_new;
                h_ovf_d = ovf_new;
            end else begin
                t_sum_d = nsum;
                t_cnt_d = cnt_new;
                t_ovf_d = ovf_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
            h_sum_q <= '0;
            h_cnt_q <= '0;
            h_ovf_q <= 1'b0;
            t_sum_q <= '0;
            t_cnt_q <= '0;
            t_ovf_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
            h_sum_q <= h_sum_d;
            h_cnt_q <= h_cnt_d;
            h_ovf_q <= h_ovf_d;
            t_sum_q <= t_sum_d;
            t_cnt_q <= t_cnt_d;
            t_ovf_q <= t_ovf_d;
            occ_q   <= occ_d;
        end
    end
endmodule

// File: doc/dot_accum.md
# dot_accum

Streaming dot-product accumulator placed directly downstream of the signed Booth/Dadda multiplier. Each cycle it accepts one signed 2*DATA_W-bit product and sign-extends it into a running ACC_W-bit sum. On the vector's last term it pushes the finished sum, term count and overflow flag into a 2-entry output queue. That queue feeds the matrix result writer over a valid/ready handshake.

## Interface
- DATA_W, 8, multiplier operand width; the product is 2*DATA_W bits, signed two's complement
- ACC_W, 24, accumulator and result width; must be at least 2*DATA_W
- LEN_W, 8, width of the term counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  2*DATA_W  signed product, from multiplier dout_C
- in_last  input  1  final term of the current vector
- out_valid  output  1  head of result queue valid
- out_ready  input  1  consumer accepts the head result
- out_sum  output  ACC_W  signed dot-product result
- out_count  output  LEN_W  number of terms in the vector, saturating
- out_ovf  output  1  signed overflow occurred at least once in this vector

## Operation
- A beat is accepted when in_valid && in_ready are high on a rising edge.
- in_ready = (queue occupancy != 2). It is combinational from registered occupancy only and never depends on in_valid, in_last or out_ready.
- Accumulator state: acc, cnt and ovf, plus a first flag that is 1 when no partial sum is held.
- On an accepted beat, p = sign-extension of in_prod to ACC_W, and base = first ? 0 : acc.
- The accepted beat computes nsum = base + p, taken mod 2^ACC_W.
- The beat flags an overflow when base and p have equal sign bits and nsum has a different sign bit.
- New ovf = (first ? 0 : ovf) | overflow.
- New cnt = first ? 1 : min(cnt+1, 2^LEN_W-1).
- If in_last is 0: acc, cnt and ovf take the new values, and first goes to 0.
- If in_last is 1: {nsum, new cnt, new ovf} is pushed into the queue tail, first goes to 1, and acc, cnt and ovf clear to 0.
- A single-beat vector (first term is also last) produces out_sum = p and out_count = 1.
- Result queue: 2-entry FIFO with registered entries. out_valid = (occupancy != 0). out_sum, out_count and out_ovf show the head entry.
- Pop happens when out_valid && out_ready.
- Push and pop in the same cycle:
  - At occupancy 1, occupancy stays 1 and the pushed entry becomes the head on the next cycle.
  - At occupancy 2, no push is possible because in_ready = 0.
- Results leave the queue in the order their vectors completed. No result is dropped or duplicated.
- While the queue is full, the partial accumulation is frozen.
- Reset: asynchronous, and all state clears. Any partial vector and queued results are discarded.
- Output values during and after reset: out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 (occupancy 0), first=1.
- Head output values when the queue is empty are don't-care after the first pop, but must read 0 immediately after reset.

## Timing
- Latency is one cycle: a last beat accepted at edge N gives out_valid=1 with its result after edge N, provided the queue was empty or popped at edge N.
- Throughput is one beat per cycle with no bubbles between vectors, including back-to-back single-beat vectors.
- in_ready falls after the edge that raises occupancy to 2. It rises after the first pop.
- Head data stays stable while out_valid && !out_ready.
- No combinational path runs from in_* to out_*, or from out_ready to in_ready.

## Test plan
- Vector of 4 products 3, -5, 16129, -16256 (last on the 4th), out_ready=1 -> one result: out_sum = -129, out_count = 4, out_ovf = 0, out_valid for exactly one cycle.
- Hold out_ready=0 and send single-beat vectors 1, 2, 3 back to back -> in_ready drops after the 2nd is accepted and beat 3 is held. Then raise out_ready -> results 1, 2, 3 appear in order, each with count 1.
- Send 512 beats of 16384 with last on the 512th, at ACC_W=24 and LEN_W=8 -> out_sum = -8388608, out_ovf = 1, out_count = 255. The next vector (single beat, 7) gives out_ovf = 0 and out_sum = 7.
- Accept 2 beats of 100, pulse rst_n low mid-vector with out_valid=0 -> all outputs read 0 during reset. Then send a single-beat vector of 7 -> out_sum = 7, count 1.
- Queue at occupancy 1 with out_ready=1, and a last beat arriving in the same cycle -> occupancy stays 1, in_ready stays 1, and the new result is the head on the next cycle.
- Assert rst_n low mid-vector with a queued result pending -> out_valid goes to 0 asynchronously and the pending result is never delivered.
